// File: rtl/jellyvl_etherneco_func_dispatch.sv
// EtherNeco slave function dispatcher: routes each packet from packet_rx to one
// function channel by type, returns that channel's replace data and keeps statistics.
module jellyvl_etherneco_func_dispatch #(
    parameter int unsigned CHANNELS      = 4,
    parameter logic [7:0]  TYPE_BASE     = 8'h10,
    parameter int unsigned COUNTER_WIDTH = 16
) (
    input  logic                              reset,
    input  logic                              clk,

    input  logic                              rx_start,
    input  logic                              rx_end,
    input  logic                              rx_error,
    input  logic [7:0]                        rx_type,
    input  logic [7:0]                        rx_node,

    input  logic                              s_first,
    input  logic                              s_last,
    input  logic [15:0]                       s_pos,
    input  logic [7:0]                        s_data,
    input  logic                              s_valid,

    output logic [7:0]                        m_replace_data,
    output logic                              m_replace_valid,

    input  logic [CHANNELS-1:0]               ch_enable,

    output logic [CHANNELS-1:0]               m_ch_start,
    output logic [CHANNELS-1:0]               m_ch_end,
    output logic [CHANNELS-1:0]               m_ch_error,
    output logic [7:0]                        m_ch_node,
    output logic                              m_ch_first,
    output logic                              m_ch_last,
    output logic [15:0]                       m_ch_pos,
    output logic [7:0]                        m_ch_data,
    output logic [CHANNELS-1:0]               m_ch_valid,

    input  logic [CHANNELS*8-1:0]             s_ch_replace_data,
    input  logic [CHANNELS-1:0]               s_ch_replace_valid,

    input  logic                              clear_counters,
    output logic [CHANNELS*COUNTER_WIDTH-1:0] ch_packet_count,
    output logic [COUNTER_WIDTH-1:0]          drop_count,
    output logic [COUNTER_WIDTH-1:0]          error_count
);

    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + COUNTER_WIDTH'(1'b1);
        end
    endfunction

    state_t                     state_r;
    state_t                     state_n_s;
    state_t                     state_close_s;
    logic [SEL_W-1:0]           sel_r;
    logic [SEL_W-1:0]           sel_n_s;
    logic [7:0]                 node_n_s;
    logic [7:0]                 idx_s;
    logic                       hit_s;
    logic [CHANNELS-1:0]        sel_oh_s;
    logic [CHANNELS-1:0]        start_n_s;
    logic [CHANNELS-1:0]        end_n_s;
    logic [CHANNELS-1:0]        error_n_s;
    logic [CHANNELS-1:0]        valid_n_s;
    logic [CHANNELS-1:0]        pkt_inc_s;
    logic                       drop_inc_s;
    logic                       err_inc_s;

    logic                       act_r;
    logic [SEL_W-1:0]           act_sel_r;
    logic                       rep_valid_s;
    logic [7:0]                 rep_data_s;

    logic [COUNTER_WIDTH-1:0]   pkt_cnt_r [CHANNELS];
    logic [COUNTER_WIDTH-1:0]   drop_cnt_r;
    logic [COUNTER_WIDTH-1:0]   err_cnt_r;

    // Close the current packet first, then decode a start that arrives in the same cycle.
    always_comb begin
        state_n_s     = state_r;
        state_close_s = state_r;
        sel_n_s       = sel_r;
        node_n_s      = m_ch_node;
        start_n_s     = '0;
        end_n_s       = '0;
        error_n_s     = '0;
        valid_n_s     = '0;
        pkt_inc_s     = '0;
        drop_inc_s    = 1'b0;
        err_inc_s     = 1'b0;
        sel_oh_s      = CHANNELS'(1'b1) << sel_r;
        idx_s         = rx_type - TYPE_BASE;

        if (32'(idx_s) < CHANNELS) begin
            hit_s = ch_enable[idx_s[SEL_W-1:0]];
        end else begin
            hit_s = 1'b0;
        end

        case (state_r)
            ST_ACTIVE: begin
                if (rx_error) begin
                    error_n_s     = sel_oh_s;
                    err_inc_s     = 1'b1;
                    state_close_s = ST_IDLE;
                end else if (rx_end) begin
                    end_n_s       = sel_oh_s;
                    pkt_inc_s     = sel_oh_s;
                    state_close_s = ST_IDLE;
                end else if (rx_start) begin
                    // missing end: the old packet is aborted by the new header
                    error_n_s     = sel_oh_s;
                    err_inc_s     = 1'b1;
                    state_close_s = ST_IDLE;
                end else begin
                    state_close_s = ST_ACTIVE;
                end
            end
            ST_DROP: begin
                if (rx_end || rx_error) begin
                    state_close_s = ST_IDLE;
                end else begin
                    state_close_s = ST_DROP;
                end
            end
            ST_IDLE: begin
                state_close_s = ST_IDLE;
            end
            default: begin
                state_close_s = ST_IDLE;
            end
        endcase

        if (rx_start) begin
            if (hit_s) begin
                state_n_s = ST_ACTIVE;
                sel_n_s   = idx_s[SEL_W-1:0];
                node_n_s  = rx_node;
                start_n_s = CHANNELS'(1'b1) << idx_s[SEL_W-1:0];
            end else begin
                state_n_s  = ST_DROP;
                drop_inc_s = 1'b1;
            end
        end else begin
            state_n_s = state_close_s;
        end

        if ((state_r == ST_ACTIVE) && s_valid) begin
            valid_n_s = sel_oh_s;
        end else begin
            valid_n_s = '0;
        end
    end

    // Replace data comes back from the channel that owned the payload one cycle earlier.
    always_comb begin
        rep_valid_s = act_r & s_ch_replace_valid[act_sel_r];
        if (rep_valid_s) begin
            rep_data_s = s_ch_replace_data[{act_sel_r, 3'b000} +: 8];
        end else begin
            rep_data_s = 8'h00;
        end
    end

    // FSM state, packet control pulses and the latched node number.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            sel_r      <= '0;
            m_ch_node  <= 8'h00;
            m_ch_start <= '0;
            m_ch_end   <= '0;
            m_ch_error <= '0;
        end else begin
            state_r    <= state_n_s;
            sel_r      <= sel_n_s;
            m_ch_node  <= node_n_s;
            m_ch_start <= start_n_s;
            m_ch_end   <= end_n_s;
            m_ch_error <= error_n_s;
        end
    end

    // Payload forwarding stage and the replace return stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ch_first      <= 1'b0;
            m_ch_last       <= 1'b0;
            m_ch_pos        <= 16'h0000;
            m_ch_data       <= 8'h00;
            m_ch_valid      <= '0;
            act_r           <= 1'b0;
            act_sel_r       <= '0;
            m_replace_data  <= 8'h00;
            m_replace_valid <= 1'b0;
        end else begin
            m_ch_first      <= s_first;
            m_ch_last       <= s_last;
            m_ch_pos        <= s_pos;
            m_ch_data       <= s_data;
            m_ch_valid      <= valid_n_s;
            act_r           <= (state_r == ST_ACTIVE);
            act_sel_r       <= sel_r;
            m_replace_data  <= rep_data_s;
            m_replace_valid <= rep_valid_s;
        end
    end

    // Saturating statistics; a clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pkt_cnt_r[i] <= '0;
            end
            drop_cnt_r <= '0;
            err_cnt_r  <= '0;
        end else if (clear_counters) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pkt_cnt_r[i] <= '0;
            end
            drop_cnt_r <= '0;
            err_cnt_r  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (pkt_inc_s[i]) begin
                    pkt_cnt_r[i] <= sat_inc(pkt_cnt_r[i]);
                end else begin
                    pkt_cnt_r[i] <= pkt_cnt_r[i];
                end
            end
            if (drop_inc_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            if (err_inc_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
        assign ch_packet_count[g*COUNTER_WIDTH +: COUNTER_WIDTH] = pkt_cnt_r[g];
    end

    assign drop_count  = drop_cnt_r;
    assign error_count = err_cnt_r;

endmodule
